// File: rtl/counter_updown_mod_pkg.sv
// rtl/counter_updown_mod_pkg.sv - shared types and load clipping helper for the up/down counter
// Package counter_pkg:
//   cnt_dir_e  : count direction (DIR_DOWN=0, DIR_UP=1), decoded from the up input
//   cnt_mode_e : range-end behaviour (MODE_WRAP=0, MODE_SAT=1), decoded from the sat input
//   clip_load  : clamps a load value to the top of the count range
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  // Values above the top of range load as the top of range, so a load can
  // never leave the counter outside 0..MAX.
  function automatic int unsigned clip_load(input int unsigned d, input int unsigned max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// rtl/counter_updown_mod_if.sv - control/status bundle for the modulo-N up/down counter
// Signals:
//   clr, load, d[WIDTH], en, up, sat : controls, driven by the master
//   q[WIDTH], tc, wrapped            : status, driven by the counter (slave)
// Modports: master (controller side), slave (counter side)
interface counter_updown_mod_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  modport master (
    output clr, load, d, en, up, sat,
    input  q, tc, wrapped
  );

  modport slave (
    input  clr, load, d, en, up, sat,
    output q, tc, wrapped
  );
endinterface

// File: rtl/counter_updown_mod_prescaler.sv
// rtl/counter_updown_mod_prescaler.sv - mod-PRESCALE enable divider for the up/down counter
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-low reset, zeroes the phase
//   en    in  advance the phase counter this cycle
//   clr   in  synchronous phase restart (takes priority over en)
//   tick  out combinational, high on the last enabled cycle of each PRESCALE group
module counter_prescaler #(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // PRESCALE=1 gives a zero-bit phase; keep one bit that simply stays at 0.
  localparam int            CW   = (WIDTH < 1) ? 1 : WIDTH;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre;

  assign tick = en & (pre == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + CW'(1);
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - modulo-N up/down counter with clear, clipped load, wrap/saturate
// Parameters: WIDTH (count bits), MAX (top of range 0..MAX), PRESCALE (enable divide ratio)
// Optional feature macro: COUNTER_PRESCALE_EN (count steps on every PRESCALE-th enabled cycle)
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-low reset
//   bus   slave modport of counter_updown_mod_if:
//         clr > load > count step > hold; q and wrapped registered, tc combinational
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter int PRESCALE = 1
) (
  input logic                 clk,
  input logic                 reset,
  counter_updown_mod_if.slave bus
);

  if ((MAX > (2 ** WIDTH) - 1) || (MAX < 1) || (PRESCALE < 1)) begin : g_bad_cfg
    $error("counter_updown_mod: illegal WIDTH/MAX/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             wrapped_r;
  logic             wrapped_next;
  logic [WIDTH-1:0] load_val;
  logic             step_en;
  logic             at_end;
  cnt_dir_e         dir;
  cnt_mode_e        mode;

`ifdef COUNTER_PRESCALE_EN
  // A load restarts the divide phase just as a clear does.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.clr | bus.load),
    .tick  (step_en)
  );
`else
  assign step_en = bus.en;
`endif

  assign dir      = cnt_dir_e'(bus.up);
  assign mode     = cnt_mode_e'(bus.sat);
  assign load_val = WIDTH'(clip_load(32'(bus.d), 32'(MAX)));

  // Sitting at the range end the next step would run past.
  assign at_end = (dir == DIR_UP) ? (q_r == TOP) : (q_r == '0);

  // Held low during reset so nothing downstream sees a spurious terminal count.
  assign bus.tc = reset & step_en & ~bus.clr & ~bus.load & at_end;

  always_comb begin
    q_next       = q_r;
    wrapped_next = 1'b0;
    if (bus.clr) begin
      q_next = '0;
    end else if (bus.load) begin
      q_next = load_val;
    end else if (step_en) begin
      if (at_end) begin
        if (mode == MODE_WRAP) begin
          q_next       = (dir == DIR_UP) ? '0 : TOP;
          wrapped_next = 1'b1;
        end
      end else begin
        q_next = (dir == DIR_UP) ? q_r + WIDTH'(1) : q_r - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r       <= '0;
      wrapped_r <= 1'b0;
    end else begin
      q_r       <= q_next;
      wrapped_r <= wrapped_next;
    end
  end

  assign bus.q       = q_r;
  assign bus.wrapped = wrapped_r;

endmodule
